// File: rtl/traffic_phase_scheduler.sv
// Sensor- and pedestrian-actuated phase sequencer for a main/side road intersection.
// Optional flashing-yellow mode is compiled in with `define FLASH_MODE_EN.
module traffic_phase_scheduler #(
  parameter int unsigned MAIN_MIN = 10,
  parameter int unsigned YELLOW   = 3,
  parameter int unsigned ALL_RED  = 1,
  parameter int unsigned SIDE_MIN = 4,
  parameter int unsigned SIDE_MAX = 12,
  parameter int unsigned WALK     = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       side_sensor,
  input  logic       ped_req,
`ifdef FLASH_MODE_EN
  input  logic       flash_req,
`endif
  output logic [2:0] main_road,
  output logic [2:0] side_road,
  output logic       ped_walk,
  output logic [2:0] phase
);

  localparam logic [2:0] StMg  = 3'd0;
  localparam logic [2:0] StMy  = 3'd1;
  localparam logic [2:0] StAra = 3'd2;
  localparam logic [2:0] StPw  = 3'd3;
  localparam logic [2:0] StSg  = 3'd4;
  localparam logic [2:0] StSy  = 3'd5;
  localparam logic [2:0] StArb = 3'd6;

  localparam logic [2:0] LampRed = 3'b100;
  localparam logic [2:0] LampYel = 3'b010;
  localparam logic [2:0] LampGrn = 3'b001;

  localparam int unsigned Max1 = (MAIN_MIN > YELLOW) ? MAIN_MIN : YELLOW;
  localparam int unsigned Max2 = (ALL_RED > SIDE_MIN) ? ALL_RED : SIDE_MIN;
  localparam int unsigned Max3 = (SIDE_MAX > WALK) ? SIDE_MAX : WALK;
  localparam int unsigned Max4 = (Max1 > Max2) ? Max1 : Max2;
  localparam int unsigned MaxP = (Max4 > Max3) ? Max4 : Max3;
  localparam int unsigned TW   = $clog2(MaxP) + 1;

  localparam logic [TW-1:0] TimerMax   = TW'(MaxP);
  localparam logic [TW-1:0] MainLast   = TW'(MAIN_MIN - 1);
  localparam logic [TW-1:0] YelLast    = TW'(YELLOW - 1);
  localparam logic [TW-1:0] RedLast    = TW'(ALL_RED - 1);
  localparam logic [TW-1:0] SideMinLst = TW'(SIDE_MIN - 1);
  localparam logic [TW-1:0] SideMaxLst = TW'(SIDE_MAX - 1);
  localparam logic [TW-1:0] WalkLast   = TW'(WALK - 1);

  logic [2:0]    r_state;
  logic [TW-1:0] r_timer;
  logic          r_ped_pending;
  logic          r_side_prio;
  logic [2:0]    r_main_road;
  logic [2:0]    r_side_road;
  logic          r_ped_walk;

  logic [2:0]    w_state_d;
  logic          w_change;
  logic          w_enter_pw;
  logic          w_enter_sg;
  logic [2:0]    w_main_d;
  logic [2:0]    w_side_d;
  logic          w_walk_d;

`ifdef FLASH_MODE_EN
  logic          r_flash_on;
  logic          w_flash_on_d;

  // Lamps are lit on FL entry and then blink on every tick.
  assign w_flash_on_d = (r_state != 3'd7) ? 1'b1 : (tick ? ~r_flash_on : r_flash_on);
`endif

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StMg:  if (tick && r_timer >= MainLast && (side_sensor || r_ped_pending)) w_state_d = StMy;
      StMy:  if (tick && r_timer >= YelLast) w_state_d = StAra;
      StAra: if (tick && r_timer >= RedLast) begin
        w_state_d = (r_ped_pending && !r_side_prio) ? StPw : StSg;
      end
      StPw:  if (tick && r_timer >= WalkLast) w_state_d = StArb;
      StSg:  if (tick && (r_timer >= SideMaxLst || (r_timer >= SideMinLst && !side_sensor))) begin
        w_state_d = StSy;
      end
      StSy:  if (tick && r_timer >= YelLast) w_state_d = StArb;
      StArb: if (tick && r_timer >= RedLast) w_state_d = StMg;
`ifdef FLASH_MODE_EN
      default: if (!flash_req) w_state_d = StArb;
`else
      default: w_state_d = StArb;
`endif
    endcase
`ifdef FLASH_MODE_EN
    if (flash_req) w_state_d = 3'd7;
`endif
  end

  assign w_change   = (w_state_d != r_state);
  assign w_enter_pw = w_change && (w_state_d == StPw);
  assign w_enter_sg = w_change && (w_state_d == StSg);

  // Outputs are decoded from the next state so they register on the same edge as it.
  always_comb begin
    w_main_d = LampRed;
    w_side_d = LampRed;
    w_walk_d = 1'b0;
    case (w_state_d)
      StMg: w_main_d = LampGrn;
      StMy: w_main_d = LampYel;
      StPw: w_walk_d = 1'b1;
      StSg: w_side_d = LampGrn;
      StSy: w_side_d = LampYel;
`ifdef FLASH_MODE_EN
      3'd7: begin
        w_main_d = w_flash_on_d ? LampYel : 3'b000;
        w_side_d = w_flash_on_d ? LampRed : 3'b000;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= StMg;
      r_timer       <= '0;
      r_ped_pending <= 1'b0;
      r_side_prio   <= 1'b0;
      r_main_road   <= LampGrn;
      r_side_road   <= LampRed;
      r_ped_walk    <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_change) begin
        r_timer <= '0;
      end else if (tick && r_timer != TimerMax) begin
        r_timer <= r_timer + 1'b1;
      end
      r_ped_pending <= ped_req | (r_ped_pending & ~w_enter_pw);
      // Prevents a second consecutive walk phase while side traffic waits.
      if (w_enter_pw && side_sensor) begin
        r_side_prio <= 1'b1;
      end else if (w_enter_sg) begin
        r_side_prio <= 1'b0;
      end
      r_main_road <= w_main_d;
      r_side_road <= w_side_d;
      r_ped_walk  <= w_walk_d;
    end
  end

`ifdef FLASH_MODE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flash_on <= 1'b0;
    end else begin
      r_flash_on <= w_flash_on_d;
    end
  end
`endif

  assign main_road = r_main_road;
  assign side_road = r_side_road;
  assign ped_walk  = r_ped_walk;
  assign phase     = r_state;

endmodule

// File: doc/traffic_phase_scheduler.md
Name: traffic_phase_scheduler

Overview:
- Sensor- and pedestrian-actuated phase sequencer for one two-road intersection (main road plus side road).
- Drives the main_road and side_road lamp vectors and a pedestrian walk lamp.
- Main road rests in green until demand arrives; side green extends while vehicles are detected, up to a ceiling.
- All dwell times count pulses of an external timebase strobe, so the block is clock-rate independent.

Parameters:
- MAIN_MIN, 10, minimum main-green dwell in ticks (must be >=1)
- YELLOW, 3, yellow dwell in ticks for either road (>=1)
- ALL_RED, 1, all-red clearance dwell in ticks (>=1)
- SIDE_MIN, 4, minimum side-green dwell in ticks (>=1)
- SIDE_MAX, 12, maximum side-green dwell in ticks (>= SIDE_MIN)
- WALK, 6, pedestrian walk dwell in ticks (>=1)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- tick  in  1  timebase strobe; one-cycle pulse, or tied high to count clocks
- side_sensor  in  1  level: vehicle present on side road
- ped_req  in  1  pedestrian button; any high cycle registers a request
- main_road  out  3  {red,yellow,green}, one-hot
- side_road  out  3  {red,yellow,green}, one-hot
- ped_walk  out  1  walk lamp
- phase  out  3  current state code

Behaviour:
- One clock domain; reset is synchronous and active-high on clk; ports named clk and rst.
- All outputs are registered Moore decodes of the state register and change on the same edge as the state.
- State codes: MG=0 (main green), MY=1 (main yellow), ARA=2 (all red A), PW=3 (pedestrian walk), SG=4 (side green), SY=5 (side yellow), ARB=6 (all red B).
- Lamp outputs per state:
  - MG: main=001, side=100
  - MY: main=010, side=100
  - SG: main=100, side=001
  - SY: main=100, side=010
  - ARA, ARB, PW: both 100
  - ped_walk=1 only in PW
- Reset (takes effect at any time, including mid-phase): state MG, main_road=001, side_road=100, ped_walk=0, phase=0, timer=0, ped_pending=0, side_prio=0.
- Timer:
  - Cleared on every state change; increments on each cycle with tick=1.
  - Width is clog2(max parameter)+1 and saturates at max.
  - "N ticks elapsed" means a tick arrives while timer==N-1; the transition occurs on that edge.
- ped_pending:
  - Set on any cycle with ped_req=1.
  - Cleared on the edge entering PW.
  - If ped_req is high on that same edge, set wins and ped_pending stays 1.
- Transitions:
  - MG -> MY: once MAIN_MIN ticks have elapsed and (side_sensor or ped_pending). With no demand, MG is held indefinitely and the timer saturates; a later demand transitions on the next tick.
  - MY -> ARA: after YELLOW ticks.
  - ARA -> PW: after ALL_RED ticks, if ped_pending and !side_prio.
  - ARA -> SG: after ALL_RED ticks, in all other cases (including no demand remaining).
  - PW -> ARB: after WALK ticks. side_prio is set on PW entry if side_sensor=1.
  - SG -> SY: when SIDE_MAX ticks have elapsed, or when at least SIDE_MIN ticks have elapsed and side_sensor=0. side_prio is cleared on SG entry.
  - SY -> ARB: after YELLOW ticks.
  - ARB -> MG: after ALL_RED ticks.
- Starvation guard: side_prio forces a pending side demand to be served before a second consecutive walk phase.
- tick=0 freezes all timing; demand latching still operates.
- Illegal state code 7: next edge goes to ARB, both roads red, ped_walk=0.
- Safety invariant: never both roads non-red in the same cycle.

Optional Feature:
- Macro FLASH_MODE_EN.
- Defined:
  - Adds input port flash_req (1 bit).
  - Code 7 becomes state FL, entered from any state on the edge after flash_req=1 is sampled (overrides all other transitions).
  - In FL, main_road alternates 010/000 and side_road alternates 100/000, toggling on each tick; ped_walk=0. On FL entry: main=010, side=100.
  - flash_req=0 -> ARB, then normal sequencing resumes. ped_pending is retained through FL.
- Undefined:
  - No flash_req port.
  - Code 7 is illegal and recovers to ARB as above.

Test Plan:
- Defaults, tick=1, no demand for 50 cycles after reset -> phase stays 0, main_road=001, side_road=100 throughout.
- side_sensor=1 from cycle 0 -> MY at cycle 10, ARA at 13, SG at 14. Sensor held -> SY at 26 (SIDE_MAX), ARB at 29, MG at 30.
- side_sensor pulsed high cycles 0-15 only -> SG entered at 14; sensor already low, so SY at 18 (SIDE_MIN=4).
- ped_req one-cycle pulse at cycle 2, no vehicles -> MY at 10, PW at 14 with ped_walk=1 for 6 cycles, ARB at 20, MG at 21; ped_pending cleared.
- ped_req and side_sensor both held -> sequence MG,MY,ARA,PW,ARB,MG,MY,ARA,SG; a second PW only after SG.
- rst asserted mid-SG for one cycle -> next edge phase=0, main_road=001, ped_walk=0, timer=0. With tick=0 for 100 cycles, phase does not change despite demand.
